// File: rtl/filter_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// filter_ctrl_pkg : shared state encoding and defaults for the filter sequencer
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package filter_ctrl_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_RUN   = 2'd1;
  localparam logic [STATE_W-1:0] ST_DRAIN = 2'd2;
  localparam logic [STATE_W-1:0] ST_DONE  = 2'd3;

  localparam int KERNEL_DEF   = 5;
  localparam int PIPE_LAT_DEF = 6;

endpackage

`default_nettype wire

// File: rtl/raster_counter.sv
// ---------------------------------------------------------------------------
// raster_counter : column/row tracker with last-pixel and window-inside flags
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module raster_counter
  import filter_ctrl_pkg::*;
#(
  parameter int COL_WIDTH = 11,
  parameter int ROW_WIDTH = 11,
  parameter int KERNEL    = KERNEL_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clear,
  input  logic                 inc,
  input  logic [COL_WIDTH-1:0] width,
  input  logic [ROW_WIDTH-1:0] height,
  output logic [COL_WIDTH-1:0] col,
  output logic [ROW_WIDTH-1:0] row,
  output logic                 last_pixel,
  output logic                 win_inside
);

  logic col_at_end;

  assign col_at_end = (col == width - COL_WIDTH'(1));
  assign last_pixel = col_at_end && (row == height - ROW_WIDTH'(1));
  assign win_inside = (col >= COL_WIDTH'(KERNEL - 1)) && (row >= ROW_WIDTH'(KERNEL - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (inc) begin
      if (col_at_end) begin
        col <= '0;
        row <= row + ROW_WIDTH'(1);
      end else begin
        col <= col + COL_WIDTH'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/filter_seq_ctrl.sv
// ---------------------------------------------------------------------------
// filter_seq_ctrl : frame sequencer for the Y-channel filter chain
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module filter_seq_ctrl
  import filter_ctrl_pkg::*;
#(
  parameter int COL_WIDTH = 11,
  parameter int ROW_WIDTH = 11,
  parameter int KERNEL    = KERNEL_DEF,
  parameter int PIPE_LAT  = PIPE_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [COL_WIDTH-1:0] i_width,
  input  logic [ROW_WIDTH-1:0] i_height,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_en,
  output logic                 o_lb_wen,
  output logic [COL_WIDTH-1:0] o_col,
  output logic [ROW_WIDTH-1:0] o_row,
  output logic                 o_win_valid,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_cfg_err
);

  localparam int                 DRAIN_W    = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(PIPE_LAT - 1);

  logic [STATE_W-1:0]   state, state_nxt;
  logic [COL_WIDTH-1:0] width_q;
  logic [ROW_WIDTH-1:0] height_q;
  logic [DRAIN_W-1:0]   drain_cnt;
  logic [COL_WIDTH-1:0] col;
  logic [ROW_WIDTH-1:0] row;
  logic                 last_pixel, win_inside;
  logic                 size_ok, start_ok, abort_act, accept, cnt_clear;

  assign size_ok   = (i_width >= COL_WIDTH'(KERNEL)) && (i_height >= ROW_WIDTH'(KERNEL));
  assign start_ok  = (state == ST_IDLE) && i_start && !i_abort && size_ok;
  assign abort_act = (state != ST_IDLE) && i_abort;
  assign accept    = i_valid && o_ready;
  assign cnt_clear = start_ok || abort_act;

  raster_counter #(
    .COL_WIDTH (COL_WIDTH),
    .ROW_WIDTH (ROW_WIDTH),
    .KERNEL    (KERNEL)
  ) u_raster (
    .clk        (clk),
    .rstn       (rstn),
    .clear      (cnt_clear),
    .inc        (accept),
    .width      (width_q),
    .height     (height_q),
    .col        (col),
    .row        (row),
    .last_pixel (last_pixel),
    .win_inside (win_inside)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_ok) state_nxt = ST_RUN;
      ST_RUN: begin
        if (i_abort)                   state_nxt = ST_IDLE;
        else if (accept && last_pixel) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (i_abort)                state_nxt = ST_IDLE;
        else if (drain_cnt == '0)   state_nxt = ST_DONE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Abort drops ready in the same cycle so no pixel is taken on the way out.
  always_comb begin
    o_ready = (state == ST_RUN) && !i_abort;
    o_busy  = (state != ST_IDLE);
    o_done  = (state == ST_DONE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      width_q  <= '0;
      height_q <= '0;
    end else if (start_ok) begin
      width_q  <= i_width;
      height_q <= i_height;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                       drain_cnt <= '0;
    else if (abort_act)                              drain_cnt <= '0;
    else if ((state == ST_RUN) && accept && last_pixel) drain_cnt <= DRAIN_LOAD;
    else if ((state == ST_DRAIN) && (drain_cnt != '0))  drain_cnt <= drain_cnt - DRAIN_W'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_en        <= 1'b0;
      o_lb_wen    <= 1'b0;
      o_col       <= '0;
      o_row       <= '0;
      o_win_valid <= 1'b0;
      o_cfg_err   <= 1'b0;
    end else begin
      o_en        <= accept;
      o_lb_wen    <= accept;
      o_col       <= accept ? col : '0;
      o_row       <= accept ? row : '0;
      o_win_valid <= accept && win_inside;
      o_cfg_err   <= (state == ST_IDLE) && i_start && !i_abort && !size_ok;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_filter_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_filter_seq_ctrl : directed self-checking bench for filter_seq_ctrl
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_filter_seq_ctrl;

  localparam int CW = 11;
  localparam int RW = 11;
  localparam int K  = 5;
  localparam int PL = 6;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          i_start = 1'b0;
  logic          i_abort = 1'b0;
  logic          i_valid = 1'b0;
  logic [CW-1:0] i_width = '0;
  logic [RW-1:0] i_height = '0;
  logic          o_ready, o_en, o_lb_wen, o_win_valid, o_busy, o_done, o_cfg_err;
  logic [CW-1:0] o_col;
  logic [RW-1:0] o_row;

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int en_cnt = 0, win_cnt = 0, done_cnt = 0, cfg_cnt = 0;
  int first_en = 0, last_en = 0, done_cyc = 0, win_col = 0, win_row = 0;
  int exp_col = 0, exp_row = 0, frame_w = 1;
  int vmode = 0;
  bit ok;

  filter_seq_ctrl #(
    .COL_WIDTH (CW),
    .ROW_WIDTH (RW),
    .KERNEL    (K),
    .PIPE_LAT  (PL)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .i_start     (i_start),
    .i_abort     (i_abort),
    .i_width     (i_width),
    .i_height    (i_height),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .o_en        (o_en),
    .o_lb_wen    (o_lb_wen),
    .o_col       (o_col),
    .o_row       (o_row),
    .o_win_valid (o_win_valid),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_cfg_err   (o_cfg_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference raster model: every o_en must carry the next expected coordinate.
  always @(negedge clk) begin
    if (o_en === 1'b1) begin
      check("en_col", 32'(o_col), exp_col);
      check("en_row", 32'(o_row), exp_row);
      check("win_valid", 32'(o_win_valid), (exp_row >= K - 1 && exp_col >= K - 1) ? 1 : 0);
      check("lb_wen", 32'(o_lb_wen), 1);
      if (o_win_valid === 1'b1) begin
        win_cnt++;
        win_col = exp_col;
        win_row = exp_row;
      end
      if (en_cnt == 0) first_en = cyc;
      last_en = cyc;
      en_cnt++;
      if (exp_col == frame_w - 1) begin
        exp_col = 0;
        exp_row++;
      end else begin
        exp_col++;
      end
    end else begin
      check("idle_strobes", 32'({o_lb_wen, o_win_valid}), 0);
    end
    if (o_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (o_cfg_err === 1'b1) cfg_cnt++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (vmode == 1)      i_valid = 1'b1;
      else if (vmode == 2) i_valid = ~i_valid;
      else                 i_valid = 1'b0;
    end
  endtask

  task automatic new_frame(input int w, input int h);
    frame_w  = w;
    exp_col  = 0;
    exp_row  = 0;
    en_cnt   = 0;
    win_cnt  = 0;
    win_col  = -1;
    win_row  = -1;
    i_width  = CW'(w);
    i_height = RW'(h);
    i_start  = 1'b1;
    step(1);
    i_start  = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    int d0;
    d0   = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (done_cnt != d0) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", 32'(seen), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctrl", 32'({o_ready, o_busy, o_done, o_cfg_err}), 0);
    check("rst_strobe", 32'({o_en, o_lb_wen, o_win_valid}), 0);
    check("rst_coord", 32'({o_col, o_row}), 0);
    rstn = 1'b1;
    step(2);

    // Undersized frame is rejected
    i_width = CW'(4); i_height = RW'(5); i_start = 1'b1;
    step(1);
    i_start = 1'b0;
    check("cfg_err_pulse", 32'(o_cfg_err), 1);
    check("cfg_err_busy", 32'(o_busy), 0);
    check("cfg_err_ready", 32'(o_ready), 0);
    step(1);
    check("cfg_err_clear", 32'(o_cfg_err), 0);
    check("cfg_err_idle", 32'(o_busy), 0);
    check("cfg_err_count", cfg_cnt, 1);

    // 5x5 frame, valid held high
    vmode = 1;
    new_frame(5, 5);
    check("run_busy", 32'(o_busy), 1);
    check("run_ready", 32'(o_ready), 1);
    wait_done(200, ok);
    check("f5_en_count", en_cnt, 25);
    check("f5_en_span", last_en - first_en, 24);
    check("f5_win_count", win_cnt, 1);
    check("f5_win_col", win_col, 4);
    check("f5_win_row", win_row, 4);
    check("f5_done_lat", done_cyc - last_en, PL);
    check("f5_busy_after", 32'(o_busy), 0);
    check("f5_ready_after", 32'(o_ready), 0);
    check("f5_done_count", done_cnt, 1);

    // 8x6 frame, valid toggling
    vmode = 2;
    new_frame(8, 6);
    wait_done(400, ok);
    check("f8_en_count", en_cnt, 48);
    check("f8_en_span", last_en - first_en, 94);
    check("f8_win_count", win_cnt, 8);
    check("f8_win_last_col", win_col, 7);
    check("f8_win_last_row", win_row, 5);
    check("f8_done_count", done_cnt, 2);

    // Abort while pixel (col 3, row 2) is offered
    vmode = 1;
    new_frame(8, 6);
    step(19);
    check("ab_prev_col", 32'(o_col), 2);
    check("ab_prev_row", 32'(o_row), 2);
    i_abort = 1'b1;
    #1;
    check("ab_ready_drop", 32'(o_ready), 0);
    step(1);
    i_abort = 1'b0;
    check("ab_busy", 32'(o_busy), 0);
    check("ab_en", 32'(o_en), 0);
    check("ab_ready", 32'(o_ready), 0);
    check("ab_en_count", en_cnt, 19);
    step(20);
    check("ab_no_done", done_cnt, 2);
    check("ab_idle", 32'(o_busy), 0);
    new_frame(5, 5);
    wait_done(200, ok);
    check("ab_next_en", en_cnt, 25);
    check("ab_next_done", done_cnt, 3);

    // Start during RUN is ignored
    new_frame(8, 6);
    step(5);
    i_width = CW'(10); i_height = RW'(10); i_start = 1'b1;
    step(1);
    i_start = 1'b0;
    check("ign_no_err", cfg_cnt, 1);
    check("ign_busy", 32'(o_busy), 1);
    wait_done(300, ok);
    check("ign_en_count", en_cnt, 48);
    check("ign_win_count", win_cnt, 8);
    check("ign_done_count", done_cnt, 4);

    // Reset asserted during DRAIN
    new_frame(5, 5);
    step(27);
    check("rd_busy", 32'(o_busy), 1);
    check("rd_ready", 32'(o_ready), 0);
    rstn = 1'b0;
    #1;
    check("rd_async_ctrl", 32'({o_ready, o_busy, o_done, o_cfg_err}), 0);
    check("rd_async_strobe", 32'({o_en, o_lb_wen, o_win_valid}), 0);
    check("rd_async_coord", 32'({o_col, o_row}), 0);
    step(2);
    rstn = 1'b1;
    step(20);
    check("rd_no_done", done_cnt, 4);
    check("rd_idle", 32'(o_busy), 0);
    check("rd_ready_idle", 32'(o_ready), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
